// File: rtl/dot_matrix_pkg.sv
// Shared constants, state encoding and row-drive helper for the dot matrix scanner.
package dot_matrix_pkg;

  localparam int unsigned NUM_ROWS = 16;
  localparam int unsigned NUM_COLS = 16;
  localparam int unsigned ROW_W    = $clog2(NUM_ROWS);

  localparam logic [NUM_ROWS-1:0] ROW_ALL_OFF = 16'hFFFF;
  localparam logic [NUM_COLS-1:0] COL_ALL_OFF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  // Active-low one-hot drive pattern for a single row.
  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_W-1:0] idx);
    return ~(NUM_ROWS'(1) << idx);
  endfunction

endpackage

// File: rtl/dot_matrix_scan_timer.sv
// Phase counter: counts 0..limit, wraps to 0 after limit, flags the last cycle.
module scan_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  assign tc_c = (cnt == limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tc_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dot_matrix_scan.sv
// Row-scan driver for a 16x16 LED matrix: blank, latch ROM column word, show, advance.
module dot_matrix_scan
  import dot_matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2500,
  parameter int unsigned BLANK_CYCLES = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [ROW_W-1:0]    row_bin,
  output logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_out,
  output logic                frame_done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);

  state_t              state, next_state;
  logic [ROW_W-1:0]    next_row_bin;
  logic [NUM_ROWS-1:0] next_row_n;
  logic [NUM_COLS-1:0] next_col_out;
  logic                next_frame_done;
  logic                timer_clr_c;
  logic                timer_tc_c;
  logic [CNT_W-1:0]    timer_limit_c;

  // Timer stays cleared while idle or being disabled so every enable starts a fresh blank.
  assign timer_clr_c   = (state == IDLE) || !en;
  assign timer_limit_c = (state == SHOW) ? SHOW_LAST : BLANK_LAST;

  scan_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr_c),
    .limit (timer_limit_c),
    .tc_c  (timer_tc_c)
  );

  always_comb begin
    next_state      = state;
    next_row_bin    = row_bin;
    next_row_n      = row_n;
    next_col_out    = col_out;
    next_frame_done = 1'b0;

    case (state)
      IDLE: begin
        next_row_bin = '0;
        next_row_n   = ROW_ALL_OFF;
        next_col_out = COL_ALL_OFF;
        if (en) begin
          next_state = BLANK;
        end
      end

      BLANK: begin
        if (!en) begin
          next_state   = IDLE;
          next_row_bin = '0;
          next_row_n   = ROW_ALL_OFF;
          next_col_out = COL_ALL_OFF;
        end else if (timer_tc_c) begin
          // row_bin has been stable all blank, so the ROM word is settled here.
          next_state   = SHOW;
          next_row_n   = row_drive(row_bin);
          next_col_out = col_in;
        end
      end

      SHOW: begin
        if (!en) begin
          next_state   = IDLE;
          next_row_bin = '0;
          next_row_n   = ROW_ALL_OFF;
          next_col_out = COL_ALL_OFF;
        end else if (timer_tc_c) begin
          next_state      = BLANK;
          next_row_bin    = row_bin + ROW_W'(1);
          next_row_n      = ROW_ALL_OFF;
          next_col_out    = COL_ALL_OFF;
          next_frame_done = (row_bin == LAST_ROW);
        end
      end

      default: begin
        next_state   = IDLE;
        next_row_bin = '0;
        next_row_n   = ROW_ALL_OFF;
        next_col_out = COL_ALL_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row_bin    <= '0;
      row_n      <= ROW_ALL_OFF;
      col_out    <= COL_ALL_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      row_bin    <= next_row_bin;
      row_n      <= next_row_n;
      col_out    <= next_col_out;
      frame_done <= next_frame_done;
    end
  end

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Randomized bench for dot_matrix_scan against a position-in-frame reference model.
module tb_dot_matrix_scan;

  localparam int TB_DIV   = 8;
  localparam int TB_BLANK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        use_rom;
  logic [15:0] col_rand;
  logic [15:0] col_in;
  logic [3:0]  row_bin;
  logic [15:0] row_n;
  logic [15:0] col_out;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  dot_matrix_scan #(
    .CLK_DIV      (TB_DIV),
    .BLANK_CYCLES (TB_BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .col_in     (col_in),
    .row_bin    (row_bin),
    .row_n      (row_n),
    .col_out    (col_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the pattern7 glyph ROM.
  function automatic logic [15:0] pattern7(input logic [3:0] r);
    case (r)
      4'd1:    return 16'h0FF0;
      4'd2:    return 16'h0010;
      default: return {4'h7, r, ~r, r};
    endcase
  endfunction

  assign col_in = use_rom ? pattern7(row_bin) : col_rand;

  // Model: k = edges since the enabling edge (0 = idle); position in the frame follows from k.
  int          k = 0;
  logic [15:0] m_col = 16'h0;

  always @(posedge clk) begin
    if (rst) k = 0;
    else if (k == 0) k = en ? 1 : 0;
    else if (!en) k = 0;
    else begin
      if ((k - 1) % TB_DIV == TB_BLANK - 1) m_col = col_in;
      k = k + 1;
    end
  end

  int          m_ph, m_r;
  logic [3:0]  e_rb;
  logic [15:0] e_rn, e_col;
  logic        e_fd;

  always_comb begin
    m_ph  = 0;
    m_r   = 0;
    e_rb  = 4'h0;
    e_rn  = 16'hFFFF;
    e_col = 16'h0000;
    e_fd  = 1'b0;
    if (k > 0) begin
      m_ph = (k - 1) % TB_DIV;
      m_r  = ((k - 1) / TB_DIV) % 16;
      e_rb = 4'(m_r);
      if (m_ph >= TB_BLANK) begin
        e_rn  = ~(16'h1 << m_r);
        e_col = m_col;
      end
      e_fd = (k > 1) && (m_ph == 0) && (m_r == 0);
    end
  end

  task automatic restart();
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; use_rom = 1'b1; col_rand = 16'h0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({row_bin, row_n, col_out, frame_done} !== {4'h0, 16'hFFFF, 16'h0000, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_hold got rb=%h rn=%h col=%h fd=%b want rb=0 rn=ffff col=0000 fd=0",
                 row_bin, row_n, col_out, frame_done);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      logic [15:0] exp_rn;
      @(negedge clk);
      exp_rn = (i < 3) ? 16'hFFFF : 16'hFFFE;
      vectors++;
      if (row_n !== exp_rn) begin
        miscompares++;
        $display("FAIL reset_release edge=%0d got rn=%h want rn=%h", i, row_n, exp_rn);
      end
    end
  endtask

  task automatic test_sampling();
    logic [15:0] prev = row_n;
    int run = 1;
    bit armed = 0;
    bit seen1 = 0, seen2 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      vectors++;
      if ({row_bin, row_n, col_out, frame_done} !== {e_rb, e_rn, e_col, e_fd}) begin
        miscompares++;
        $display("FAIL sampling_model got rb=%h rn=%h col=%h fd=%b want rb=%h rn=%h col=%h fd=%b",
                 row_bin, row_n, col_out, frame_done, e_rb, e_rn, e_col, e_fd);
      end
      if (row_n == 16'hFFFD) begin
        seen1 = 1;
        vectors++;
        if (col_out !== 16'h0FF0) begin
          miscompares++;
          $display("FAIL sampling_row1 got col=%h want col=0ff0", col_out);
        end
      end
      if (row_n == 16'hFFFB) begin
        seen2 = 1;
        vectors++;
        if (col_out !== 16'h0010) begin
          miscompares++;
          $display("FAIL sampling_row2 got col=%h want col=0010", col_out);
        end
      end
      if (row_n === prev) run++;
      else begin
        if (armed) begin
          vectors++;
          if (run != ((prev == 16'hFFFF) ? TB_BLANK : TB_DIV - TB_BLANK)) begin
            miscompares++;
            $display("FAIL sampling_run rn=%h got len=%0d want len=%0d", prev, run,
                     (prev == 16'hFFFF) ? TB_BLANK : TB_DIV - TB_BLANK);
          end
        end
        armed = 1; run = 1; prev = row_n;
      end
    end
    vectors++;
    if (!(seen1 && seen2)) begin
      miscompares++;
      $display("FAIL sampling_seen got row1=%0d row2=%0d want 1 1", seen1, seen2);
    end
  endtask

  task automatic test_frame();
    int last_fd = -1, npulse = 0, last_chg = -1;
    logic prev_fd = 1'b0;
    logic [3:0] prev_rb = 4'h0;
    restart();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      vectors++;
      if ({row_bin, row_n, col_out, frame_done} !== {e_rb, e_rn, e_col, e_fd}) begin
        miscompares++;
        $display("FAIL frame_model got rb=%h rn=%h col=%h fd=%b want rb=%h rn=%h col=%h fd=%b",
                 row_bin, row_n, col_out, frame_done, e_rb, e_rn, e_col, e_fd);
      end
      if (frame_done) begin
        vectors++;
        if (prev_fd || (last_fd >= 0 && c - last_fd != 16 * TB_DIV)) begin
          miscompares++;
          $display("FAIL frame_spacing got gap=%0d prev_fd=%b want gap=%0d prev_fd=0",
                   c - last_fd, prev_fd, 16 * TB_DIV);
        end
        last_fd = c; npulse++;
      end
      if (row_bin !== prev_rb) begin
        if (last_chg >= 0) begin
          vectors++;
          if (c - last_chg != TB_DIV) begin
            miscompares++;
            $display("FAIL frame_row_period rb=%h got %0d want %0d", row_bin, c - last_chg, TB_DIV);
          end
        end
        last_chg = c;
      end
      prev_fd = frame_done;
      prev_rb = row_bin;
    end
    vectors++;
    if (npulse != 2) begin
      miscompares++;
      $display("FAIL frame_count got %0d want 2", npulse);
    end
  endtask

  task automatic test_disable();
    bit found = 0;
    restart();
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      vectors++;
      if ({row_bin, row_n, col_out, frame_done} !== {e_rb, e_rn, e_col, e_fd}) begin
        miscompares++;
        $display("FAIL disable_model got rb=%h rn=%h col=%h fd=%b want rb=%h rn=%h col=%h fd=%b",
                 row_bin, row_n, col_out, frame_done, e_rb, e_rn, e_col, e_fd);
      end
      if (row_n == 16'hFFDF) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL disable_wait got row5 never lit want lit within 200 cycles");
    end
    @(negedge clk);
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({row_bin, row_n, col_out, frame_done} !== {4'h0, 16'hFFFF, 16'h0000, 1'b0}) begin
        miscompares++;
        $display("FAIL disable_off got rb=%h rn=%h col=%h fd=%b want rb=0 rn=ffff col=0000 fd=0",
                 row_bin, row_n, col_out, frame_done);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      logic [15:0] exp_rn;
      @(negedge clk);
      exp_rn = (i < 3) ? 16'hFFFF : 16'hFFFE;
      vectors++;
      if ({row_bin, row_n} !== {4'h0, exp_rn}) begin
        miscompares++;
        $display("FAIL disable_reenable edge=%0d got rb=%h rn=%h want rb=0 rn=%h",
                 i, row_bin, row_n, exp_rn);
      end
    end
  endtask

  task automatic test_glitch();
    logic [15:0] prev_rn, prev_col;
    use_rom = 1'b0;
    col_rand = 16'($urandom);
    restart();
    prev_rn = 16'hFFFF; prev_col = 16'h0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      vectors++;
      if ({row_bin, row_n, col_out, frame_done} !== {e_rb, e_rn, e_col, e_fd}) begin
        miscompares++;
        $display("FAIL glitch_model got rb=%h rn=%h col=%h fd=%b want rb=%h rn=%h col=%h fd=%b",
                 row_bin, row_n, col_out, frame_done, e_rb, e_rn, e_col, e_fd);
      end
      if (row_n != 16'hFFFF && row_n == prev_rn) begin
        vectors++;
        if (col_out !== prev_col) begin
          miscompares++;
          $display("FAIL glitch_hold rn=%h got col=%h want col=%h", row_n, col_out, prev_col);
        end
      end
      prev_rn = row_n; prev_col = col_out;
      col_rand = 16'($urandom);
    end
  endtask

  task automatic test_invariant();
    int last_row = -1, gap = 0, idx;
    use_rom = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 99) != 0);
      col_rand = 16'($urandom);
      @(negedge clk);
      vectors++;
      if ({row_bin, row_n, col_out, frame_done} !== {e_rb, e_rn, e_col, e_fd}) begin
        miscompares++;
        $display("FAIL inv_model c=%0d got rb=%h rn=%h col=%h fd=%b want rb=%h rn=%h col=%h fd=%b",
                 c, row_bin, row_n, col_out, frame_done, e_rb, e_rn, e_col, e_fd);
      end
      vectors++;
      if ($countones(~row_n) > 1) begin
        miscompares++;
        $display("FAIL inv_onehot c=%0d got rn=%h want at most one low bit", c, row_n);
      end
      if (row_n == 16'hFFFF) gap++;
      else begin
        idx = 0;
        for (int b = 0; b < 16; b++) if (!row_n[b]) idx = b;
        if (last_row >= 0 && idx != last_row) begin
          vectors++;
          if (gap < TB_BLANK) begin
            miscompares++;
            $display("FAIL inv_gap c=%0d got gap=%0d want >= %0d", c, gap, TB_BLANK);
          end
        end
        last_row = idx; gap = 0;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; use_rom = 1'b1; col_rand = 16'h0;
    test_reset();
    test_sampling();
    test_frame();
    test_disable();
    test_glitch();
    test_invariant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
